rf_write_arbiter: RTL and testbench

Sequencer and arbiter for the architectural register file write port. It shares the single `wen/waddr/wdata` port between `NUM_REQ` writeback/commit requesters using round-robin valid/ready handshakes. After reset it zero-fills every register, because the register array itself has no reset beyond entry 0. It sits between the commit lanes and the register file and drives the register file write port directly from flops.

---
 rtl/rf_write_arbiter.sv | 149 ++++++++++++++
 tb/tb_rf_write_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a post-reset zero-fill sweep.
// Optional perf counters are enabled with `define RF_ARB_PERF_COUNT_EN.

module rf_arb_lane #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          gnt,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  output logic [AW-1:0] sel_addr,
  output logic [DW-1:0] sel_data
);
  // AND-OR mux leg: an ungranted lane contributes zero to the write mux.
  assign sel_addr = addr & {AW{gnt}};
  assign sel_data = data & {DW{gnt}};
endmodule

module rf_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           rf_wen,
  output logic [ADDR_WIDTH-1:0]          rf_waddr,
  output logic [DATA_WIDTH-1:0]          rf_wdata,
`ifdef RF_ARB_PERF_COUNT_EN
  output logic [31:0]                    perf_grant_cnt,
  output logic [31:0]                    perf_conflict_cnt,
`endif
  output logic                           init_done
);
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {INIT, RUN} state_t;

  state_t                                 state;
  logic [ADDR_WIDTH-1:0]                  cnt;
  logic [PTR_W-1:0]                       ptr, gnt_idx, next_ptr, idx_w;
  logic [NUM_REQ-1:0]                     grant;
  logic                                   xfer;
  int                                     idx;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     lane_addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     lane_data;
  logic [ADDR_WIDTH-1:0]                  mux_addr;
  logic [DATA_WIDTH-1:0]                  mux_data;

  // Rotating search from ptr; only req_valid, ptr and state feed the grant.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    xfer    = 1'b0;
    idx     = 0;
    idx_w   = '0;
    if (state == RUN) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        idx_w = PTR_W'(idx);
        if (!xfer && req_valid[idx_w]) begin
          xfer         = 1'b1;
          grant[idx_w] = 1'b1;
          gnt_idx      = idx_w;
        end
      end
    end
  end

  assign req_ready = grant;
  assign next_ptr  = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    rf_arb_lane #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_lane (
      .gnt      (grant[i]),
      .addr     (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .data     (req_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .sel_addr (lane_addr[i]),
      .sel_data (lane_data[i])
    );
  end

  always_comb begin
    mux_addr = '0;
    mux_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mux_addr = mux_addr | lane_addr[i];
      mux_data = mux_data | lane_data[i];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT;
      cnt       <= '0;
      ptr       <= '0;
      rf_wen    <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          rf_wen   <= 1'b1;
          rf_waddr <= cnt;
          rf_wdata <= '0;
          cnt      <= cnt + ADDR_WIDTH'(1);
          if (cnt == '1) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          // x0 writes still handshake but never reach the array.
          rf_wen <= xfer && (mux_addr != '0);
          if (xfer) begin
            rf_waddr <= mux_addr;
            rf_wdata <= mux_data;
            ptr      <= next_ptr;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef RF_ARB_PERF_COUNT_EN
  logic multi_valid;
  assign multi_valid = |(req_valid & (req_valid - NUM_REQ'(1)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_grant_cnt    <= '0;
      perf_conflict_cnt <= '0;
    end else if (state == RUN) begin
      if (xfer && perf_grant_cnt != '1)
        perf_grant_cnt <= perf_grant_cnt + 32'd1;
      if (multi_valid && perf_conflict_cnt != '1)
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed table, randomized traffic against a behavioural model,
// and mid-run reset. Perf counters are checked when RF_ARB_PERF_COUNT_EN is defined.

module tb_rf_write_arbiter;
  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  logic                 clock;
  logic                 reset_n;
  logic [N-1:0]         req_valid;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][DW-1:0] req_data;
  logic [N-1:0]         req_ready;
  logic                 rf_wen;
  logic [AW-1:0]        rf_waddr;
  logic [DW-1:0]        rf_wdata;
  logic                 init_done;
`ifdef RF_ARB_PERF_COUNT_EN
  logic [31:0]          perf_grant_cnt;
  logic [31:0]          perf_conflict_cnt;
`endif

  rf_write_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .req_valid         (req_valid),
    .req_addr          (req_addr),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .rf_wen            (rf_wen),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
`ifdef RF_ARB_PERF_COUNT_EN
    .perf_grant_cnt    (perf_grant_cnt),
    .perf_conflict_cnt (perf_conflict_cnt),
`endif
    .init_done         (init_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Behavioural model: sweep is a countdown of remaining fill writes, then plain
  // round-robin picking by modular search from the last winner + 1.
  int            m_fill_left;
  int            m_ptr;
  logic          m_wen, m_done;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic [N-1:0]  m_last_g;

  function automatic void m_reset();
    m_fill_left = DEPTH;
    m_ptr = 0;
    m_wen = 0; m_waddr = '0; m_wdata = '0; m_done = 0;
    m_last_g = '0;
  endfunction

  function automatic logic [N-1:0] m_grant(input logic [N-1:0] v);
    logic [N-1:0] g = '0;
    if (m_fill_left > 0) return g;
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (v[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  function automatic void m_edge(input logic [N-1:0] v, input logic [N-1:0][AW-1:0] a,
                                 input logic [N-1:0][DW-1:0] d);
    logic [N-1:0] g = m_grant(v);
    m_last_g = g;
    if (m_fill_left > 0) begin
      m_wen = 1; m_waddr = AW'(DEPTH - m_fill_left); m_wdata = '0;
      m_fill_left--;
      if (m_fill_left == 0) m_done = 1;
    end else begin
      m_wen = 0;
      for (int i = 0; i < N; i++)
        if (g[i]) begin
          m_wen = (a[i] != 0); m_waddr = a[i]; m_wdata = d[i];
          m_ptr = (i + 1) % N;
        end
    end
  endfunction

  // One cycle: drive, check grant mid-cycle, clock, check registered outputs.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0][AW-1:0] a,
                      input logic [N-1:0][DW-1:0] d, output logic [N-1:0] rdy);
    req_valid = v; req_addr = a; req_data = d;
    @(negedge clock);
    rdy = req_ready;
    chk("req_ready", 64'(req_ready), 64'(m_grant(v)));
    @(posedge clock);
    m_edge(v, a, d);
    #1;
    chk("rf_wen", 64'(rf_wen), 64'(m_wen));
    chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
    chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
    chk("init_done", 64'(init_done), 64'(m_done));
  endtask

  typedef struct {
    logic [N-1:0]  v;
    int            oi;
    logic [AW-1:0] oa;
    logic [DW-1:0] od;
    logic [N-1:0]  er;
    logic          ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t tbl[17];

  initial begin
    logic [N-1:0][AW-1:0] a, da;
    logic [N-1:0][DW-1:0] d, dd;
    logic [N-1:0]         rdy;
    logic [N-1:0]         pend;

    // Row defaults: requester i -> addr 8+i, data 0xA0+i; oi overrides one requester.
    tbl[0]  = '{4'b1111, -1, 5'd0, 32'h0,        4'b0001, 1'b1, 5'd8,  32'hA0};
    tbl[1]  = '{4'b0000, -1, 5'd0, 32'h0,        4'b0000, 1'b0, 5'd8,  32'hA0};
    tbl[2]  = '{4'b0100,  2, 5'd5, 32'hDEADBEEF, 4'b0100, 1'b1, 5'd5,  32'hDEADBEEF};
    tbl[3]  = '{4'b0000, -1, 5'd0, 32'h0,        4'b0000, 1'b0, 5'd5,  32'hDEADBEEF};
    tbl[4]  = '{4'b1111, -1, 5'd0, 32'h0,        4'b1000, 1'b1, 5'd11, 32'hA3};
    tbl[5]  = '{4'b1111, -1, 5'd0, 32'h0,        4'b0001, 1'b1, 5'd8,  32'hA0};
    tbl[6]  = '{4'b1111, -1, 5'd0, 32'h0,        4'b0010, 1'b1, 5'd9,  32'hA1};
    tbl[7]  = '{4'b1111, -1, 5'd0, 32'h0,        4'b0100, 1'b1, 5'd10, 32'hA2};
    tbl[8]  = '{4'b1111, -1, 5'd0, 32'h0,        4'b1000, 1'b1, 5'd11, 32'hA3};
    tbl[9]  = '{4'b1111, -1, 5'd0, 32'h0,        4'b0001, 1'b1, 5'd8,  32'hA0};
    tbl[10] = '{4'b1111, -1, 5'd0, 32'h0,        4'b0010, 1'b1, 5'd9,  32'hA1};
    tbl[11] = '{4'b1111, -1, 5'd0, 32'h0,        4'b0100, 1'b1, 5'd10, 32'hA2};
    tbl[12] = '{4'b0010,  1, 5'd0, 32'h1234,     4'b0010, 1'b0, 5'd0,  32'h1234};
    tbl[13] = '{4'b1111, -1, 5'd0, 32'h0,        4'b0100, 1'b1, 5'd10, 32'hA2};
    tbl[14] = '{4'b1001, -1, 5'd0, 32'h0,        4'b1000, 1'b1, 5'd11, 32'hA3};
    tbl[15] = '{4'b1001, -1, 5'd0, 32'h0,        4'b0001, 1'b1, 5'd8,  32'hA0};
    tbl[16] = '{4'b1000, -1, 5'd0, 32'h0,        4'b1000, 1'b1, 5'd11, 32'hA3};

    for (int i = 0; i < N; i++) begin
      da[i] = AW'(8 + i);
      dd[i] = DW'(32'hA0 + i);
    end

    // Reset state, with all requesters already valid.
    m_reset();
    reset_n = 1'b0;
    req_valid = '1; req_addr = da; req_data = dd;
    repeat (2) @(negedge clock);
    chk("rst_wen", 64'(rf_wen), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);

    @(posedge clock);
    #1 reset_n = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      step('1, da, dd, rdy);
      chk("sweep_addr", 64'(rf_waddr), 64'(k));
    end
    chk("sweep_done", 64'(init_done), 64'd1);

    // Directed table.
    for (int r = 0; r < 17; r++) begin
      a = da; d = dd;
      if (tbl[r].oi >= 0) begin
        a[tbl[r].oi] = tbl[r].oa;
        d[tbl[r].oi] = tbl[r].od;
      end
      step(tbl[r].v, a, d, rdy);
      chk("tbl_ready", 64'(rdy), 64'(tbl[r].er));
      chk("tbl_wen", 64'(rf_wen), 64'(tbl[r].ew));
      chk("tbl_waddr", 64'(rf_waddr), 64'(tbl[r].ea));
      chk("tbl_wdata", 64'(rf_wdata), 64'(tbl[r].ed));
    end

    // Randomized traffic: requests held until granted, occasionally withdrawn.
    pend = '0; a = '0; d = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i] && m_last_g[i]) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(1, 0) == 1) begin
          pend[i] = 1'b1;
          a[i] = ($urandom_range(7, 0) == 0) ? '0 : AW'($urandom);
          d[i] = $urandom;
        end else if (pend[i] && $urandom_range(15, 0) == 0) begin
          pend[i] = 1'b0;
        end
      end
      step(pend, a, d, rdy);
    end

    // Reset asserted right after a transfer is registered: clears with no clock edge.
    step('1, da, dd, rdy);
    chk("pre_rst_wen", 64'(rf_wen), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_wen", 64'(rf_wen), 64'd0);
    chk("async_ready", 64'(req_ready), 64'd0);
    chk("async_waddr", 64'(rf_waddr), 64'd0);
    chk("async_done", 64'(init_done), 64'd0);
    @(posedge clock);
    #1;
    chk("held_rst_wen", 64'(rf_wen), 64'd0);
    m_reset();
    reset_n = 1'b1;
    for (int k = 0; k < DEPTH; k++) step('1, da, dd, rdy);
    chk("resweep_done", 64'(init_done), 64'd1);
    chk("resweep_last", 64'(rf_waddr), 64'(DEPTH - 1));

`ifdef RF_ARB_PERF_COUNT_EN
    chk("perf_grant_init", 64'(perf_grant_cnt), 64'd0);
    chk("perf_conf_init", 64'(perf_conflict_cnt), 64'd0);
    for (int c = 0; c < 3; c++) step(4'b1001, da, dd, rdy);
    step(4'b1000, da, dd, rdy);
    chk("perf_conflict", 64'(perf_conflict_cnt), 64'd3);
    chk("perf_grant", 64'(perf_grant_cnt), 64'd4);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
